dmem_responder: RTL and testbench

Memory-side responder for the pipeline's data-memory port. It accepts load/store requests issued by the M stage over a valid/ready handshake and returns one response per request after a programmable number of wait states. It drives a stall indication back toward the hazard logic. It replaces the zero-latency data memory with a timing-realistic slave.

---
 rtl/dmem_pkg.sv | 11 +
 rtl/dmem_ram.sv | 22 ++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;
  localparam int WAIT_W = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/dmem_ram.sv
// Single-port word array: synchronous write, combinational read.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave with programmable wait states; optional out-of-range
// checking is enabled with DMEM_RANGE_CHK_EN.
//
// state | meaning
// IDLE  | no request outstanding, ready to accept
// WAIT  | request latched, counting down wait states, new requests ignored
// RESP  | response pulse on rsp_valid, ready to accept the next request
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
`ifdef DMEM_RANGE_CHK_EN
  ,
  output logic              rsp_err
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  state_t            state, nextState;
  logic [WAIT_W-1:0] waitCnt, waitCntNext;
  logic              latchedWe;
  logic [31:0]       latchedAddr;
  logic [DATA_W-1:0] latchedWdata;
  logic              accept, commit, useReq;
  logic              opWe;
  logic [31:0]       opAddr;
  logic [DATA_W-1:0] opWdata;
  logic              addrHiSet;
  logic              ramWe;
  logic [DATA_W-1:0] ramRdata;

  assign req_ready = (state != WAIT);
  assign busy      = (state == WAIT);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    nextState   = state;
    waitCntNext = waitCnt;
    commit      = 1'b0;
    useReq      = 1'b0;
    case (state)
      IDLE, RESP: begin
        nextState = IDLE;
        if (accept) begin
          if (WAIT_CYC == 0) begin
            nextState = RESP;
            commit    = 1'b1;
            useReq    = 1'b1;
          end else begin
            nextState   = WAIT;
            waitCntNext = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (waitCnt == '0) begin
          nextState = RESP;
          commit    = 1'b1;
        end else begin
          waitCntNext = waitCnt - 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so the
  // operation comes straight from the request bus rather than the latches.
  assign opWe    = useReq ? req_we    : latchedWe;
  assign opAddr  = useReq ? req_addr  : latchedAddr;
  assign opWdata = useReq ? req_wdata : latchedWdata;

`ifdef DMEM_RANGE_CHK_EN
  assign addrHiSet = |opAddr[31:ADDR_W];
`else
  assign addrHiSet = 1'b0;
  logic unusedAddrHi;
  assign unusedAddrHi = |opAddr[31:ADDR_W];
`endif

  assign ramWe = commit && opWe && !addrHiSet && !rst;

  dmem_ram #(.ADDR_W(ADDR_W)) uRam (
    .clk  (clk),
    .we   (ramWe),
    .addr (opAddr[ADDR_W-1:0]),
    .wdata(opWdata),
    .rdata(ramRdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      waitCnt      <= '0;
      rsp_rdata    <= '0;
      latchedWe    <= 1'b0;
      latchedAddr  <= '0;
      latchedWdata <= '0;
`ifdef DMEM_RANGE_CHK_EN
      rsp_err      <= 1'b0;
`endif
    end else begin
      state   <= nextState;
      waitCnt <= waitCntNext;
      if (accept) begin
        latchedWe    <= req_we;
        latchedAddr  <= req_addr;
        latchedWdata <= req_wdata;
      end
      if (commit) rsp_rdata <= addrHiSet ? '0 : (opWe ? opWdata : ramRdata);
`ifdef DMEM_RANGE_CHK_EN
      rsp_err <= commit && addrHiSet;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        v2, we2, rdy2, val2, busy2;
  logic [31:0] addr2, wdata2, rdata2;
  logic        v0, we0, rdy0, val0, busy0;
  logic [31:0] addr0, wdata0, rdata0;
`ifdef DMEM_RANGE_CHK_EN
  logic        err2, err0;
`endif

  int nCmp = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .WAIT_CYC(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_we(we2), .req_addr(addr2),
    .req_wdata(wdata2), .req_ready(rdy2), .rsp_valid(val2), .rsp_rdata(rdata2),
    .busy(busy2)
`ifdef DMEM_RANGE_CHK_EN
    , .rsp_err(err2)
`endif
  );

  dmem_responder #(.ADDR_W(8), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_we(we0), .req_addr(addr0),
    .req_wdata(wdata0), .req_ready(rdy0), .rsp_valid(val0), .rsp_rdata(rdata0),
    .busy(busy0)
`ifdef DMEM_RANGE_CHK_EN
    , .rsp_err(err0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request to dut2 and advance to its RESP cycle.
  task automatic txn2(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    v2 = 1'b1; we2 = we; addr2 = addr; wdata2 = wdata;
    step();
    v2 = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    v2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
    v0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    step();
    step();

    check("rst_ready",  32'(rdy2),  32'd1);
    check("rst_valid",  32'(val2),  32'd0);
    check("rst_busy",   32'(busy2), 32'd0);
    check("rst_rdata",  rdata2,     32'h0);
    check("rst_ready0", 32'(rdy0),  32'd1);
    check("rst_valid0", 32'(val0),  32'd0);
`ifdef DMEM_RANGE_CHK_EN
    check("rst_err",    32'(err2),  32'd0);
`endif
    rst = 1'b0;

    // Basic store with full cycle-by-cycle check
    v2 = 1'b1; we2 = 1'b1; addr2 = 32'd5; wdata2 = 32'hDEADBEEF;
    step();
    v2 = 1'b0;
    check("st_c1_busy",  32'(busy2), 32'd1);
    check("st_c1_ready", 32'(rdy2),  32'd0);
    check("st_c1_valid", 32'(val2),  32'd0);
    step();
    check("st_c2_busy",  32'(busy2), 32'd1);
    check("st_c2_valid", 32'(val2),  32'd0);
    step();
    check("st_c3_valid", 32'(val2),  32'd1);
    check("st_c3_busy",  32'(busy2), 32'd0);
    check("st_c3_ready", 32'(rdy2),  32'd1);
    check("st_c3_rdata", rdata2,     32'hDEADBEEF);

    // Load of the same address issued in the store's RESP cycle
    v2 = 1'b1; we2 = 1'b0; addr2 = 32'd5; wdata2 = 32'h0;
    step();
    v2 = 1'b0;
    check("raw_c1_busy",  32'(busy2), 32'd1);
    check("raw_c1_valid", 32'(val2),  32'd0);
    step();
    check("raw_c2_valid", 32'(val2),  32'd0);
    step();
    check("raw_c3_valid", 32'(val2),  32'd1);
    check("raw_c3_rdata", rdata2,     32'hDEADBEEF);
    step();
    check("hold_valid", 32'(val2), 32'd0);
    check("hold_ready", 32'(rdy2), 32'd1);
    check("hold_rdata", rdata2,    32'hDEADBEEF);

    // Reset mid-store discards the pending write
    txn2(1'b1, 32'd7, 32'h11);
    check("pre_st7_rdata", rdata2, 32'h11);
    v2 = 1'b1; we2 = 1'b1; addr2 = 32'd7; wdata2 = 32'h22;
    step();
    v2 = 1'b0;
    check("mid_busy", 32'(busy2), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_ready", 32'(rdy2),  32'd1);
    check("mrst_valid", 32'(val2),  32'd0);
    check("mrst_busy",  32'(busy2), 32'd0);
    check("mrst_rdata", rdata2,     32'h0);
    step();
    check("mrst_idle_valid", 32'(val2), 32'd0);
    txn2(1'b0, 32'd7, 32'h0);
    check("ld7_valid", 32'(val2), 32'd1);
    check("ld7_rdata", rdata2,    32'h11);

    // Alias / range check on address 0x100
    txn2(1'b1, 32'h0, 32'h5A5A);
    check("st0_rdata", rdata2, 32'h5A5A);
    txn2(1'b1, 32'h100, 32'hA5);
    check("st100_valid", 32'(val2), 32'd1);
`ifdef DMEM_RANGE_CHK_EN
    check("st100_rdata", rdata2,    32'h0);
    check("st100_err",   32'(err2), 32'd1);
`else
    check("st100_rdata", rdata2,    32'hA5);
`endif
    txn2(1'b0, 32'h0, 32'h0);
`ifdef DMEM_RANGE_CHK_EN
    check("ld0_rdata", rdata2,    32'h5A5A);
    check("ld0_err",   32'(err2), 32'd0);
`else
    check("ld0_rdata", rdata2,    32'hA5);
`endif

    // Requests held during WAIT are ignored
    step();
    v2 = 1'b1; we2 = 1'b1; addr2 = 32'd9; wdata2 = 32'h33;
    step();
    addr2 = 32'd10; wdata2 = 32'h44;
    step();
    check("ign_busy", 32'(busy2), 32'd1);
    step();
    check("ign_valid", 32'(val2), 32'd1);
    check("ign_rdata", rdata2,    32'h33);
    v2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("ign_noextra%0d", i), 32'(val2), 32'd0);
    end
    txn2(1'b0, 32'd9, 32'h0);
    check("ld9_rdata", rdata2, 32'h33);

    // Zero wait states: one request per cycle
    for (int i = 0; i < 4; i++) begin
      v0 = 1'b1; we0 = 1'b1; addr0 = 32'(20 + i); wdata0 = 32'h100 + 32'(i);
      step();
      check($sformatf("z_st%0d_valid", i), 32'(val0),  32'd1);
      check($sformatf("z_st%0d_busy", i),  32'(busy0), 32'd0);
      check($sformatf("z_st%0d_rdata", i), rdata0,     32'h100 + 32'(i));
    end
    for (int i = 0; i < 4; i++) begin
      we0 = 1'b0; addr0 = 32'(20 + i); wdata0 = 32'h0;
      step();
      check($sformatf("z_ld%0d_valid", i), 32'(val0),  32'd1);
      check($sformatf("z_ld%0d_busy", i),  32'(busy0), 32'd0);
      check($sformatf("z_ld%0d_rdata", i), rdata0,     32'h100 + 32'(i));
    end
    v0 = 1'b0;
    step();
    check("z_end_valid", 32'(val0), 32'd0);
    check("z_end_ready", 32'(rdy0), 32'd1);
    check("z_end_rdata", rdata0,    32'h103);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
